// File: rtl/i2s_record_rx.sv
// I2S slave capture path: synchronizes the codec bit stream, frames 16-bit PCM words,
// buffers them in a small FIFO and writes them to SDRAM through a req/ack write port.
module i2s_record_rx #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk50,
  input  logic        reset_n,
  input  logic        rec_en,
  input  logic        stereo_en,
  input  logic        wrap_en,
  input  logic [24:0] ADDR_start,
  input  logic [24:0] ADDR_end,
  input  logic        I2S_SCLK,
  input  logic        I2S_LRCLK,
  input  logic        I2S_DOUT,
  output logic        ram_we,
  output logic [24:0] ram_address,
  output logic [15:0] ram_data,
  input  logic        ram_ack,
  output logic        rec_done,
  output logic        overflow,
  output logic [24:0] word_count
);

  localparam int unsigned AW = 25;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 5;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t state, next_state;

  logic [2:0]    sclk_sync;
  logic [1:0]    lr_sync;
  logic [1:0]    dout_sync;
  logic          sr_c;
  logic          lr_c;
  logic          dout_c;

  logic          lr_prev;
  logic          chan;
  logic [DW-1:0] shift;
  logic [BW-1:0] bit_cnt;
  logic          word_valid;

  logic          rec_en_d;
  logic          armed;
  logic          capturing;
  logic [AW-1:0] start_q;
  logic [AW-1:0] end_q;
  logic          arm_c;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty_c;
  logic          fifo_full_c;
  logic          push_c;
  logic          push_ok_c;
  logic          pop_c;
  logic          flush_c;

  logic          adv_c;
  logic          at_end_c;
  logic          done_c;

  // Two-flop synchronizers; sclk_sync[2] holds the previous synchronized SCLK
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      lr_sync   <= '0;
      dout_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], I2S_SCLK};
      lr_sync   <= {lr_sync[0], I2S_LRCLK};
      dout_sync <= {dout_sync[0], I2S_DOUT};
    end
  end

  assign sr_c   = sclk_sync[1] & ~sclk_sync[2];
  assign lr_c   = lr_sync[1];
  assign dout_c = dout_sync[1];

  // Slot framing: the bit sampled with the LRCLK change is the delay slot
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      lr_prev    <= 1'b0;
      chan       <= 1'b0;
      shift      <= '0;
      bit_cnt    <= BW'(16);
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (sr_c) begin
        lr_prev <= lr_c;
        if (lr_c != lr_prev) begin
          bit_cnt <= '0;
          chan    <= lr_c;
          shift   <= '0;
        end else if (bit_cnt < BW'(16)) begin
          shift   <= {shift[DW-2:0], dout_c};
          bit_cnt <= bit_cnt + BW'(1);
          if (bit_cnt == BW'(15)) begin
            word_valid <= ~chan | stereo_en;
          end
        end
      end
    end
  end

  assign arm_c = rec_en & ~rec_en_d;

  // Arming: capture opens only at the next left-channel slot start
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      rec_en_d  <= 1'b1;
      armed     <= 1'b0;
      capturing <= 1'b0;
      start_q   <= '0;
      end_q     <= '0;
    end else begin
      rec_en_d <= rec_en;
      if (arm_c) begin
        armed     <= 1'b1;
        capturing <= 1'b0;
        start_q   <= ADDR_start;
        end_q     <= ADDR_end;
      end else if (!rec_en || done_c) begin
        armed     <= 1'b0;
        capturing <= 1'b0;
      end else if (armed && sr_c && lr_prev && !lr_c) begin
        armed     <= 1'b0;
        capturing <= 1'b1;
      end
    end
  end

  assign fifo_empty_c = (count == '0);
  assign fifo_full_c  = (count == CW'(FIFO_DEPTH));
  assign push_c       = word_valid & capturing;
  assign push_ok_c    = push_c & (~fifo_full_c | pop_c);
  assign flush_c      = arm_c | done_c;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (arm_c) begin
        overflow <= 1'b0;
      end else if (push_c && fifo_full_c && !pop_c) begin
        overflow <= 1'b1;
      end
      if (flush_c) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok_c) wr_ptr <= wr_ptr + PW'(1);
        if (pop_c)     rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push_ok_c) - CW'(pop_c);
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (push_ok_c && !flush_c) begin
      mem[wr_ptr] <= shift;
    end
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // The head word moves into ram_data on request entry, freeing its FIFO slot
  always_comb begin
    next_state = state;
    pop_c      = 1'b0;
    adv_c      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!arm_c && !rec_done && !fifo_empty_c) begin
          next_state = S_REQ;
          pop_c      = 1'b1;
        end
      end
      S_REQ: begin
        if (arm_c) begin
          next_state = S_IDLE;
        end else if (ram_ack) begin
          next_state = S_IDLE;
          adv_c      = 1'b1;
        end
      end
    endcase
  end

  assign at_end_c = (ram_address == end_q);
  assign done_c   = adv_c & at_end_c & ~wrap_en;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      ram_we      <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      rec_done    <= 1'b0;
      word_count  <= '0;
    end else begin
      ram_we <= (next_state == S_REQ);
      if (pop_c) begin
        ram_data <= mem[rd_ptr];
      end
      if (arm_c) begin
        ram_address <= ADDR_start;
        rec_done    <= 1'b0;
        word_count  <= '0;
      end else if (adv_c) begin
        word_count <= word_count + AW'(1);
        if (at_end_c) begin
          if (wrap_en) ram_address <= start_q;
          else         rec_done    <= 1'b1;
        end else begin
          ram_address <= ram_address + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_record_rx.sv
// Directed bench for i2s_record_rx: codec BFM with 32-bit slots plus a delayed-ack arbiter model.
module tb_i2s_record_rx;

  logic        clk50 = 1'b0;
  logic        reset_n;
  logic        rec_en;
  logic        stereo_en;
  logic        wrap_en;
  logic [24:0] addr_start;
  logic [24:0] addr_end;
  logic        sclk;
  logic        lrclk;
  logic        dout;
  logic        ram_we;
  logic [24:0] ram_address;
  logic [15:0] ram_data;
  logic        ram_ack;
  logic        rec_done;
  logic        overflow;
  logic [24:0] word_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int ack_delay    = 3;
  bit ack_en       = 1'b1;

  logic [24:0] wa_q[$];
  logic [15:0] wd_q[$];

  always #10 clk50 = ~clk50;

  i2s_record_rx #(.FIFO_DEPTH(4)) dut (
    .clk50      (clk50),
    .reset_n    (reset_n),
    .rec_en     (rec_en),
    .stereo_en  (stereo_en),
    .wrap_en    (wrap_en),
    .ADDR_start (addr_start),
    .ADDR_end   (addr_end),
    .I2S_SCLK   (sclk),
    .I2S_LRCLK  (lrclk),
    .I2S_DOUT   (dout),
    .ram_we     (ram_we),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_ack    (ram_ack),
    .rec_done   (rec_done),
    .overflow   (overflow),
    .word_count (word_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One SCLK period: 4 clk50 low, 4 clk50 high; LRCLK/data change with the falling edge
  task automatic sclk_bit(input logic lr, input logic d);
    @(negedge clk50);
    sclk  = 1'b0;
    lrclk = lr;
    dout  = d;
    repeat (4) @(negedge clk50);
    sclk = 1'b1;
    repeat (3) @(negedge clk50);
  endtask

  task automatic send_slot(input logic lr, input logic [15:0] w, input logic fill);
    for (int k = 0; k < 32; k++) begin
      sclk_bit(lr, (k >= 1 && k <= 16) ? w[16-k] : fill);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input logic fill);
    send_slot(1'b0, l, fill);
    send_slot(1'b1, r, fill);
  endtask

  task automatic arm(input logic [24:0] s, input logic [24:0] e, input logic st, input logic wr);
    @(negedge clk50);
    rec_en     = 1'b0;
    addr_start = s;
    addr_end   = e;
    stereo_en  = st;
    wrap_en    = wr;
    wa_q.delete();
    wd_q.delete();
    repeat (2) @(negedge clk50);
    rec_en = 1'b1;
    repeat (4) @(negedge clk50);
  endtask

  task automatic drain();
    repeat (40) @(negedge clk50);
  endtask

  // Arbiter model: ack pulse ack_delay cycles after ram_we, logging the accepted word
  initial begin
    int wait_cnt;
    ram_ack  = 1'b0;
    wait_cnt = 0;
    forever begin
      @(negedge clk50);
      if (ram_ack) begin
        ram_ack  = 1'b0;
        wait_cnt = 0;
      end else if (ram_we && ack_en) begin
        if (wait_cnt >= ack_delay - 1) begin
          ram_ack = 1'b1;
          wa_q.push_back(ram_address);
          wd_q.push_back(ram_data);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp2 [4];
    exp2 = '{16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};

    reset_n    = 1'b0;
    rec_en     = 1'b0;
    stereo_en  = 1'b0;
    wrap_en    = 1'b0;
    addr_start = '0;
    addr_end   = '0;
    sclk       = 1'b0;
    lrclk      = 1'b1;
    dout       = 1'b0;
    repeat (5) @(negedge clk50);

    check("rst_we",    32'(ram_we),      32'h0);
    check("rst_addr",  32'(ram_address), 32'h0);
    check("rst_data",  32'(ram_data),    32'h0);
    check("rst_done",  32'(rec_done),    32'h0);
    check("rst_ovf",   32'(overflow),    32'h0);
    check("rst_count", 32'(word_count),  32'h0);

    reset_n = 1'b1;
    send_frame(16'hFFFF, 16'hFFFF, 1'b0);
    drain();
    check("idle_no_write", 32'(wa_q.size()), 32'd0);

    // Mono capture
    arm(25'h100, 25'h1FF, 1'b0, 1'b1);
    repeat (3) send_frame(16'hA5C3, 16'h1234, 1'b0);
    drain();
    check("mono_writes", 32'(wa_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      check($sformatf("mono_addr%0d", i), 32'(wa_q[i]), 32'h100 + 32'(i));
      check($sformatf("mono_data%0d", i), 32'(wd_q[i]), 32'hA5C3);
    end
    check("mono_count", 32'(word_count), 32'd3);

    // Stereo with trailing ones in the 32-bit slots
    arm(25'h200, 25'h2FF, 1'b1, 1'b1);
    repeat (2) send_frame(16'h8001, 16'h7FFE, 1'b1);
    drain();
    check("st_writes", 32'(wa_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      check($sformatf("st_addr%0d", i), 32'(wa_q[i]), 32'h200 + 32'(i));
      check($sformatf("st_data%0d", i), 32'(wd_q[i]), 32'(exp2[i]));
    end

    // Arming in the middle of an R slot
    @(negedge clk50);
    rec_en     = 1'b0;
    stereo_en  = 1'b1;
    addr_start = 25'h300;
    addr_end   = 25'h3FF;
    wa_q.delete();
    wd_q.delete();
    repeat (4) @(negedge clk50);
    fork
      begin
        send_frame(16'h1111, 16'h2222, 1'b0);
        send_frame(16'h3333, 16'h4444, 1'b0);
      end
      begin
        repeat (320) @(negedge clk50);
        rec_en = 1'b1;
      end
    join
    drain();
    check("align_writes", 32'(wa_q.size()), 32'd2);
    if (wa_q.size() >= 2) begin
      check("align_data0", 32'(wd_q[0]), 32'h3333);
      check("align_data1", 32'(wd_q[1]), 32'h4444);
      check("align_addr0", 32'(wa_q[0]), 32'h300);
    end

    // End address without wrap
    arm(25'h0, 25'h3, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_frame(16'(i + 1), 16'hBEEF, 1'b0);
    drain();
    check("end_writes", 32'(wa_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      check($sformatf("end_addr%0d", i), 32'(wa_q[i]), 32'(i));
      check($sformatf("end_data%0d", i), 32'(wd_q[i]), 32'(i + 1));
    end
    check("end_done",  32'(rec_done),   32'h1);
    check("end_we",    32'(ram_we),     32'h0);
    check("end_count", 32'(word_count), 32'd4);

    // End address with wrap
    arm(25'h0, 25'h3, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) send_frame(16'(i + 1), 16'hBEEF, 1'b0);
    drain();
    check("wrap_writes", 32'(wa_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < wa_q.size(); i++) begin
      check($sformatf("wrap_addr%0d", i), 32'(wa_q[i]), 32'(i % 4));
    end
    check("wrap_done",  32'(rec_done),   32'h0);
    check("wrap_count", 32'(word_count), 32'd6);

    // Overflow with ack withheld
    ack_en = 1'b0;
    arm(25'h40, 25'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_frame(16'h10 + 16'(i), 16'hBEEF, 1'b0);
    check("ovf_flag",    32'(overflow),       32'h1);
    check("ovf_held_we", 32'(ram_we),         32'h1);
    check("ovf_none",    32'(wa_q.size()),    32'd0);
    ack_en = 1'b1;
    drain();
    check("ovf_writes", 32'(wa_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < wa_q.size(); i++) begin
      check($sformatf("ovf_data%0d", i), 32'(wd_q[i]), 32'h10 + 32'(i));
      check($sformatf("ovf_addr%0d", i), 32'(wa_q[i]), 32'h40 + 32'(i));
    end
    check("ovf_sticky", 32'(overflow), 32'h1);

    // Reset while a request is pending
    ack_en = 1'b0;
    arm(25'h80, 25'hFF, 1'b0, 1'b0);
    send_frame(16'hC0DE, 16'hBEEF, 1'b0);
    repeat (10) @(negedge clk50);
    check("mid_pre_we", 32'(ram_we), 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_we",    32'(ram_we),      32'h0);
    check("mid_addr",  32'(ram_address), 32'h0);
    check("mid_data",  32'(ram_data),    32'h0);
    check("mid_done",  32'(rec_done),    32'h0);
    check("mid_ovf",   32'(overflow),    32'h0);
    check("mid_count", 32'(word_count),  32'h0);
    ack_en = 1'b1;
    repeat (3) @(negedge clk50);
    reset_n = 1'b1;
    repeat (2) send_frame(16'hC0DE, 16'hBEEF, 1'b0);
    drain();
    check("post_rst_none", 32'(wa_q.size()), 32'd0);
    arm(25'h80, 25'hFF, 1'b0, 1'b0);
    send_frame(16'h5A5A, 16'hBEEF, 1'b0);
    drain();
    check("rearm_writes", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() >= 1) begin
      check("rearm_data", 32'(wd_q[0]), 32'h5A5A);
      check("rearm_addr", 32'(wa_q[0]), 32'h80);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
